// File: rtl/id_token_stat.sv
// Token statistics for the identifier lexer: splits the char stream at TERM and
// reports length, count and longest length of every token the identifier FSM accepted.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no bytes since the last TERM, run_len == 0
// SCAN  | one or more non-TERM bytes seen in this token
module id_token_stat #(
    parameter int          LEN_W = 6,
    parameter int          CNT_W = 8,
    parameter logic [7:0]  TERM  = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       char,
    input  logic             match,
    output logic             done,
    output logic [LEN_W-1:0] id_len,
    output logic [CNT_W-1:0] id_count,
    output logic [LEN_W-1:0] max_len,
    output logic             overflow
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] run_len, run_len_nxt;
    logic [LEN_W-1:0] id_len_nxt, max_len_nxt;
    logic [CNT_W-1:0] id_count_nxt;
    logic             done_nxt, overflow_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            run_len  <= '0;
            done     <= 1'b0;
            id_len   <= '0;
            id_count <= '0;
            max_len  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            run_len  <= run_len_nxt;
            done     <= done_nxt;
            id_len   <= id_len_nxt;
            id_count <= id_count_nxt;
            max_len  <= max_len_nxt;
            overflow <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        run_len_nxt  = run_len;
        done_nxt     = 1'b0;
        id_len_nxt   = id_len;
        id_count_nxt = id_count;
        max_len_nxt  = max_len;
        overflow_nxt = overflow;

        if (char != TERM) begin
            state_nxt = SCAN;
            // a byte arriving with the counter already full is what flags overflow
            if (run_len == LEN_MAX)
                overflow_nxt = 1'b1;
            else
                run_len_nxt = run_len + LEN_ONE;
        end else begin
            state_nxt   = IDLE;
            run_len_nxt = '0;
            if (state == SCAN && match) begin
                done_nxt   = 1'b1;
                id_len_nxt = run_len;
                if (id_count != CNT_MAX)
                    id_count_nxt = id_count + CNT_ONE;
                if (run_len > max_len)
                    max_len_nxt = run_len;
            end
        end
    end

endmodule

// File: doc/id_token_stat.md
Name: id_token_stat

Overview:
- Downstream consumer of the identifier-recognition FSM. Watches the same 8-bit char stream that feeds the FSM, plus the FSM's `out` flag, wired here as `match`.
- Splits the stream into tokens at a terminator byte. For each token the FSM accepted, reports its length, counts accepted tokens, and tracks the longest one.
- Feeds the status/display logic that sits after the lexer front end.

Parameters:
- LEN_W, 6, width of token-length counters; lengths saturate at 2^LEN_W-1.
- CNT_W, 8, width of the accepted-identifier counter; saturates at 2^CNT_W-1.
- TERM, 8'h00, terminator byte that ends a token.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- char  input  8  current stream byte; one byte consumed per clock, no valid qualifier.
- match  input  1  FSM `out`; in the cycle a byte is presented, `match` reflects the prefix of all bytes before it since the last TERM.
- done  output  1  one-cycle pulse: an accepted identifier just ended.
- id_len  output  LEN_W  length of the most recent accepted identifier; held until the next accepted identifier.
- id_count  output  CNT_W  number of accepted identifiers since reset.
- max_len  output  LEN_W  largest id_len since reset.
- overflow  output  1  sticky; set when any token's length counter saturated.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - done, id_len, id_count, max_len and overflow all clear to 0.
  - Internal run_len clears to 0 and the state goes to IDLE.
  - Reset asserted mid-token discards that token; no done is produced for it.
- States:
  - IDLE: run_len==0, no bytes since the last TERM.
  - SCAN: one or more non-TERM bytes seen.
- Per rising edge, char!=TERM:
  - run_len <= run_len+1, saturating at 2^LEN_W-1.
  - If run_len is already at max, hold it and set overflow <= 1.
  - Transition to SCAN.
  - done <= 0.
- Per rising edge, char==TERM in SCAN, match==1 (accepted token):
  - done <= 1.
  - id_len <= run_len.
  - id_count <= id_count+1, saturating; no wrap.
  - max_len <= max(max_len, run_len).
  - run_len <= 0; state goes to IDLE.
- Per rising edge, char==TERM in SCAN, match==0 (rejected token):
  - done <= 0; id_len, id_count and max_len unchanged.
  - run_len <= 0; state goes to IDLE.
- Per rising edge, char==TERM in IDLE:
  - Empty token; ignored regardless of match.
  - done <= 0; nothing else changes.
  - This covers repeated terminators and the TERM byte present on char immediately after reset.
- Latency: done, id_len, id_count and max_len become valid in the cycle after the edge that sampled the TERM byte. done is high for exactly one cycle.
- Back-to-back tokens: a TERM followed immediately by a non-TERM byte starts the new token with run_len=1 at the next edge. Minimum spacing between done pulses is 2 cycles (1-byte identifier plus TERM).
- Saturated token:
  - Still counted if accepted, with id_len = 2^LEN_W-1.
  - overflow stays 1 until reset.
- `match` is sampled only on TERM cycles; its value during non-TERM bytes is don't-care.
- All outputs are registered; there is no combinational path from char or match to any output.

Test Plan:
- Reset, hold char=8'h00 for 10 cycles -> all outputs 0, no done pulse.
- Drive "ABCD0123" (8'h41..8'h44, 8'h30..8'h33), then 8'h00 with match=1 -> next cycle: done=1 for one cycle, id_len=8, id_count=1, max_len=8.
- Continue with "AB01", then 8'h00 with match=1 -> id_len=4, id_count=2, max_len stays 8. Then "0A", then 8'h00 with match=0 -> no done, id_len=4, id_count=2.
- Two consecutive 8'h00 bytes after a token, second with match=1 -> exactly one done pulse for the first terminator, none for the second.
- Drive 70 letters, then 8'h00 with match=1 (LEN_W=6) -> id_len=63, overflow=1; overflow still 1 after 5 further short tokens.
- Drive "ABC", pulse rst_n low for 1 cycle, then "XY" and 8'h00 with match=1 -> id_len=2, id_count=1.
- Run 300 accepted 1-byte tokens with CNT_W=8 -> id_count holds at 255.
